handwrite_canvas: RTL and testbench
===================================

# handwrite_canvas

Capture buffer that builds the 30x30 one-bit handwriting bitmap consumed by the digit classifier. Accepts pen sample points, stamps a square brush into a 900-bit register, supports clear, and on submit issues the classifier's active-low start pulse. The bitmap is frozen until the classifier reports its result.

## Interface
- W, 30, canvas width in pixels
- H, 30, canvas height in pixels
- BRUSH, 1, brush half-size; stamp is (2*BRUSH+1)^2 pixels centred on the point (0 = single pixel)
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_pt_valid  in  1  pen sample valid
- o_pt_ready  out  1  sample accepted when i_pt_valid & o_pt_ready
- i_pt_x  in  5  sample column, 0..W-1
- i_pt_y  in  5  sample row, 0..H-1
- i_pen_down  in  1  sample is a drawing sample; 0 = hover, discarded
- i_clear  in  1  clear request, sampled only in IDLE
- i_submit  in  1  submit request, sampled only in IDLE
- i_result_valid  in  1  classifier result strobe (digit valid)
- o_handwrite  out  W*H  bitmap; bit index y*W+x, 1 = ink
- o_submit_n  out  1  one-cycle active-low start pulse to classifier
- o_pixel_count  out  10  number of set pixels
- o_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, PAINT, CLEAR, LOCK.
- o_pt_ready = (state == IDLE) & !i_clear & !i_submit.
- IDLE priority, same cycle: i_clear > i_submit > point. A request that loses priority is not retained.
- IDLE, accepted point with i_pen_down=0: dropped, stay IDLE.
- IDLE, accepted point with i_pen_down=1: latch x,y; go PAINT.
- PAINT: walk offsets dy = -BRUSH..+BRUSH (outer), dx = -BRUSH..+BRUSH (inner), one offset per cycle, (2*BRUSH+1)^2 cycles total. Target (x+dx, y+dy) is written to 1 only if 0 <= x+dx < W and 0 <= y+dy < H; out-of-range offsets still consume their cycle, no wraparound. Return to IDLE after last offset.
- Points with x >= W or y >= H: accepted, brush still centred there; only in-range pixels of the stamp are written.
- o_pixel_count increments by 1 only on a 0->1 pixel transition; rewriting an inked pixel does not count. Saturation not required (max 900 fits 10 bits).
- CLEAR: o_pixel_count <= 0 on entry; zero one row (W bits) per cycle, rows 0..H-1, H cycles, then IDLE.
- IDLE, i_submit with o_pixel_count == 0: ignored, no pulse, stay IDLE.
- IDLE, i_submit with o_pixel_count > 0: go LOCK; o_submit_n low for exactly the first LOCK cycle.
- LOCK: o_handwrite held constant; points, clear, submit all ignored. i_result_valid=1 -> IDLE next cycle; bitmap retained (user must clear explicitly).
- i_result_valid outside LOCK: ignored.

## Timing
- Reset (i_rst=1 at edge): state IDLE, o_handwrite all 0, o_pixel_count 0, o_submit_n 1, o_busy 0; o_pt_ready 1 after reset once i_clear/i_submit low. Reset mid-PAINT/CLEAR/LOCK aborts immediately, same values.
- Point accept at edge N: pixel for offset k written at edge N+1+k; o_pt_ready low from N+1 through N+(2*BRUSH+1)^2, high again next cycle. BRUSH=1: 9 busy cycles.
- Clear at edge N: row r zero after edge N+1+r; IDLE after edge N+H (30 cycles busy).
- Submit at edge N: o_submit_n low for cycle after N only; bitmap stable from N until IDLE re-entry; classifier sees a stable bitmap for its full ~900-cycle scan.
- o_pixel_count updates on the same edge as the pixel write.

## Test plan
- Reset, then point (10,10) pen_down, BRUSH=1 -> bits (9..11, 9..11) set, o_pixel_count=9, ready low exactly 9 cycles.
- Point (0,0) then point (29,29), BRUSH=1 -> 4 pixels each corner, no wrap bits (e.g. bit 899 set, bit 29 and bit 870 clear), count=8.
- Same point (5,5) twice, then pen_down=0 point (20,20) -> count stays 9, (20,20) clear, hover accepted in 1 cycle.
- Submit with empty canvas -> o_submit_n stays 1, state IDLE; draw, submit -> single low pulse, points/clear ignored, bitmap unchanged until i_result_valid, then ready high.
- i_clear and i_submit and valid point same IDLE cycle -> clear wins, 30 busy cycles, bitmap all 0, count 0, no submit pulse.
- Assert i_rst in cycle 3 of PAINT and in LOCK -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/handwrite_canvas.sv
// handwrite_canvas: 30x30 one-bit handwriting capture buffer.
// Pen samples stamp a square brush into the bitmap, one brush offset
// per cycle. Clear wipes one row per cycle. Submit issues the active-low
// classifier start pulse and freezes the bitmap until the result arrives.
module handwrite_canvas #(
  parameter int W     = 30,
  parameter int H     = 30,
  parameter int BRUSH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pt_valid,
  output logic             o_pt_ready,
  input  logic [4:0]       i_pt_x,
  input  logic [4:0]       i_pt_y,
  input  logic             i_pen_down,
  input  logic             i_clear,
  input  logic             i_submit,
  input  logic             i_result_valid,
  output logic [W*H-1:0]   o_handwrite,
  output logic             o_submit_n,
  output logic [9:0]       o_pixel_count,
  output logic             o_busy
);

  localparam int N  = W * H;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(H);

  localparam logic signed [7:0] WS = 8'(W);
  localparam logic signed [7:0] HS = 8'(H);
  localparam logic signed [7:0] BS = 8'(BRUSH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAINT,
    S_CLEAR,
    S_LOCK
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         x_q, x_d;
  logic [4:0]         y_q, y_d;
  logic signed [7:0]  dx_q, dx_d;
  logic signed [7:0]  dy_q, dy_d;
  logic [RW-1:0]      row_q, row_d;
  logic [N-1:0]       bm_q, bm_d;
  logic [9:0]         cnt_q, cnt_d;
  logic               sub_n_q, sub_n_d;

  logic signed [7:0]  px, py;
  logic               in_range;
  logic [IW-1:0]      pidx;
  logic [IW-1:0]      rbase;

  // Brush target address and row base for the current PAINT / CLEAR step.
  always_comb begin
    px       = $signed({3'b000, x_q}) + dx_q;
    py       = $signed({3'b000, y_q}) + dy_q;
    in_range = (px >= 8'sd0) && (px < WS) && (py >= 8'sd0) && (py < HS);
    pidx     = IW'(py) * IW'(W) + IW'(px);
    rbase    = IW'(row_q) * IW'(W);
  end

  // Next-state, bitmap and pixel-count update.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    row_d   = row_q;
    bm_d    = bm_q;
    cnt_d   = cnt_q;
    sub_n_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (i_clear) begin
          state_d = S_CLEAR;
          row_d   = '0;
          cnt_d   = '0;
        end else if (i_submit) begin
          if (cnt_q != '0) begin
            state_d = S_LOCK;
            sub_n_d = 1'b0;
          end
        end else if (i_pt_valid && i_pen_down) begin
          x_d     = i_pt_x;
          y_d     = i_pt_y;
          dx_d    = -BS;
          dy_d    = -BS;
          state_d = S_PAINT;
        end
      end
      S_PAINT: begin
        // Only a 0->1 transition is counted; out-of-range offsets still take their cycle.
        if (in_range && !bm_q[pidx]) begin
          bm_d[pidx] = 1'b1;
          cnt_d      = cnt_q + 10'd1;
        end
        if (dx_q == BS) begin
          dx_d = -BS;
          if (dy_q == BS) begin
            state_d = S_IDLE;
          end else begin
            dy_d = dy_q + 8'sd1;
          end
        end else begin
          dx_d = dx_q + 8'sd1;
        end
      end
      S_CLEAR: begin
        bm_d[rbase +: W] = '0;
        if (row_q == RW'(H - 1)) begin
          state_d = S_IDLE;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      S_LOCK: begin
        if (i_result_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      row_q   <= '0;
      bm_q    <= '0;
      cnt_q   <= '0;
      sub_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      row_q   <= row_d;
      bm_q    <= bm_d;
      cnt_q   <= cnt_d;
      sub_n_q <= sub_n_d;
    end
  end

  assign o_pt_ready    = (state_q == S_IDLE) && !i_clear && !i_submit;
  assign o_busy        = (state_q != S_IDLE);
  assign o_handwrite   = bm_q;
  assign o_submit_n    = sub_n_q;
  assign o_pixel_count = cnt_q;

endmodule

// File: tb/tb_handwrite_canvas.sv
// Bench for handwrite_canvas: fixed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a pixel-array model.
module tb_handwrite_canvas;

  localparam int W     = 30;
  localparam int H     = 30;
  localparam int BRUSH = 1;

  logic           clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_pt_valid = 1'b0;
  logic           o_pt_ready;
  logic [4:0]     i_pt_x = '0;
  logic [4:0]     i_pt_y = '0;
  logic           i_pen_down = 1'b0;
  logic           i_clear = 1'b0;
  logic           i_submit = 1'b0;
  logic           i_result_valid = 1'b0;
  logic [W*H-1:0] o_handwrite;
  logic           o_submit_n;
  logic [9:0]     o_pixel_count;
  logic           o_busy;

  always #5 clk = ~clk;

  handwrite_canvas #(.W(W), .H(H), .BRUSH(BRUSH)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_pt_valid     (i_pt_valid),
    .o_pt_ready     (o_pt_ready),
    .i_pt_x         (i_pt_x),
    .i_pt_y         (i_pt_y),
    .i_pen_down     (i_pen_down),
    .i_clear        (i_clear),
    .i_submit       (i_submit),
    .i_result_valid (i_result_valid),
    .o_handwrite    (o_handwrite),
    .o_submit_n     (o_submit_n),
    .o_pixel_count  (o_pixel_count),
    .o_busy         (o_busy)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  bit          mpix [H][W];
  int unsigned mcount = 0;

  typedef struct {
    int x;
    int y;
    bit pen;
    int exp_busy;
    int exp_count;
  } vec_t;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [W*H-1:0] model_vec();
    logic [W*H-1:0] v;
    v = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        v[y*W+x] = mpix[y][x];
    return v;
  endfunction

  task automatic check_bm(input string nm);
    logic [W*H-1:0] e;
    int first;
    int ndiff;
    e = model_vec();
    first = -1;
    ndiff = 0;
    for (int i = 0; i < W*H; i++) begin
      if (o_handwrite[i] !== e[i]) begin
        if (first < 0) first = i;
        ndiff++;
      end
    end
    n_total++;
    if (ndiff == 0) n_pass++;
    else $display("FAIL %s: %0d bitmap bits differ, first at index %0d got %b expected %b",
                  nm, ndiff, first, o_handwrite[first], e[first]);
  endtask

  task automatic model_stamp(input int x, input int y);
    for (int dy = -BRUSH; dy <= BRUSH; dy++)
      for (int dx = -BRUSH; dx <= BRUSH; dx++) begin
        int tx, ty;
        tx = x + dx;
        ty = y + dy;
        if (tx >= 0 && tx < W && ty >= 0 && ty < H && !mpix[ty][tx]) begin
          mpix[ty][tx] = 1'b1;
          mcount++;
        end
      end
  endtask

  task automatic model_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mpix[y][x] = 1'b0;
    mcount = 0;
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_busy"}, o_busy, 0);
    check({nm, "_submit_n"}, o_submit_n, 1);
    check({nm, "_count"}, o_pixel_count, 0);
    check({nm, "_ready"}, o_pt_ready, 1);
    check({nm, "_bitmap_zero"}, (o_handwrite == '0), 1);
  endtask

  // Present one sample once ready; returns number of cycles ready stays low.
  task automatic send_point(input int x, input int y, input bit pen, output int busy);
    int t;
    busy = 0;
    @(negedge clk);
    t = 0;
    while (!o_pt_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_pt_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    i_pt_valid = 1'b1;
    i_pt_x     = 5'(x);
    i_pt_y     = 5'(y);
    i_pen_down = pen;
    @(posedge clk);
    #1 i_pt_valid = 1'b0;
    @(negedge clk);
    while (!o_pt_ready && busy < 200) begin
      busy++;
      @(negedge clk);
    end
    if (pen) model_stamp(x, y);
  endtask

  task automatic do_clear(input bit with_others);
    int busy;
    int pulses;
    @(negedge clk);
    i_clear = 1'b1;
    if (with_others) begin
      i_submit   = 1'b1;
      i_pt_valid = 1'b1;
      i_pt_x     = 5'd3;
      i_pt_y     = 5'd3;
      i_pen_down = 1'b1;
    end
    @(posedge clk);
    #1;
    i_clear    = 1'b0;
    i_submit   = 1'b0;
    i_pt_valid = 1'b0;
    busy   = 0;
    pulses = 0;
    @(negedge clk);
    while (o_busy && busy < 200) begin
      busy++;
      if (!o_submit_n) pulses++;
      @(negedge clk);
    end
    model_clear();
    check("clear_busy_cycles", busy, H);
    check("clear_no_pulse", pulses, 0);
    check("clear_count", o_pixel_count, 0);
    check_bm("clear_bitmap");
  endtask

  task automatic do_submit(input int hold);
    bit lock;
    int bad;
    @(negedge clk);
    i_submit = 1'b1;
    @(negedge clk);
    i_submit = 1'b0;
    lock = (mcount != 0);
    check("submit_pulse", o_submit_n, lock ? 0 : 1);
    check("submit_busy", o_busy, lock);
    if (lock) begin
      bad = 0;
      repeat (hold) begin
        i_pt_valid = 1'b1;
        i_pt_x     = 5'($urandom_range(0, 29));
        i_pt_y     = 5'($urandom_range(0, 29));
        i_pen_down = 1'b1;
        i_clear    = 1'($urandom_range(0, 1));
        i_submit   = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (o_submit_n !== 1'b1 || o_pt_ready !== 1'b0 || o_busy !== 1'b1 ||
            o_handwrite !== model_vec()) bad++;
      end
      i_pt_valid = 1'b0;
      i_clear    = 1'b0;
      i_submit   = 1'b0;
      check("lock_hold", bad, 0);
      i_result_valid = 1'b1;
      @(negedge clk);
      i_result_valid = 1'b0;
      check("unlock_busy", o_busy, 0);
      check("unlock_ready", o_pt_ready, 1);
    end else begin
      @(negedge clk);
      check("empty_submit_no_pulse", o_submit_n, 1);
      check("empty_submit_idle", o_busy, 0);
    end
    check("submit_count", o_pixel_count, mcount);
    check_bm("submit_bitmap");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int busy;
    tbl = '{
      '{10, 10, 1'b1, 9, 9},
      '{ 0,  0, 1'b1, 9, 13},
      '{29, 29, 1'b1, 9, 17},
      '{ 5,  5, 1'b1, 9, 26},
      '{ 5,  5, 1'b1, 9, 26},
      '{20, 20, 1'b0, 0, 26},
      '{31, 31, 1'b1, 9, 26},
      '{30,  5, 1'b1, 9, 29},
      '{ 9, 12, 1'b1, 9, 36}
    };
    model_clear();

    // Reset values.
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    check_reset_values("reset");

    // Submit on an empty canvas is ignored.
    do_submit(1);

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      send_point(tbl[i].x, tbl[i].y, tbl[i].pen, busy);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
      check($sformatf("vec%0d_count", i), o_pixel_count, tbl[i].exp_count);
      check_bm($sformatf("vec%0d_bitmap", i));
    end

    // Corner and brush-shape spot checks.
    check("bit899_set", o_handwrite[899], 1);
    check("bit29_nowrap", o_handwrite[29], 0);
    check("bit870_nowrap", o_handwrite[870], 0);
    check("pix20_20_hover", o_handwrite[20*W+20], 0);
    for (int y = 9; y <= 11; y++)
      for (int x = 9; x <= 11; x++)
        check($sformatf("brush_%0d_%0d", x, y), o_handwrite[y*W+x], 1);

    // Submit with ink: single pulse, frozen bitmap, release on result.
    do_submit(12);

    // Clear wins over submit and point in the same cycle.
    do_clear(1'b1);

    // Reset during the third PAINT cycle.
    @(negedge clk);
    i_pt_valid = 1'b1;
    i_pt_x     = 5'd12;
    i_pt_y     = 5'd20;
    i_pen_down = 1'b1;
    @(posedge clk);
    #1 i_pt_valid = 1'b0;
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    model_clear();
    check_reset_values("rst_paint");

    // Reset during LOCK.
    send_point(4, 4, 1'b1, busy);
    @(negedge clk);
    i_submit = 1'b1;
    @(negedge clk);
    i_submit = 1'b0;
    check("lock_entry_pulse", o_submit_n, 0);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    model_clear();
    check_reset_values("rst_lock");

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_clear(1'b0);
      end else if (r == 1) begin
        do_submit($urandom_range(1, 6));
      end else begin
        int x, y;
        bit pen;
        x   = $urandom_range(0, 31);
        y   = $urandom_range(0, 31);
        pen = ($urandom_range(0, 3) != 0);
        send_point(x, y, pen, busy);
        check("rnd_busy", busy, pen ? 9 : 0);
        check("rnd_count", o_pixel_count, mcount);
        check_bm("rnd_bitmap");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
